// File: rtl/spi_multi_master_if.sv
// Shared serial bus of the multi-lane SPI sender: one SCK/SSEL pair framing NCH data lanes.
interface spi_multi_master_if #(
    parameter int NCH = 2
);
    logic           SCK;
    logic           SSEL;
    logic [NCH-1:0] DATA_OUT;

    modport master (output SCK, SSEL, DATA_OUT);
    modport slave  (input  SCK, SSEL, DATA_OUT);
endinterface

// File: rtl/spi_multi_master.sv
// Multi-lane SPI mode-0 word sender: NCH lanes shifted MSB first on a shared SCK/SSEL,
// with frame counting, sticky overrun detection and a frame-done strobe.
module spi_multi_master #(
    parameter int NCH   = 2,
    parameter int WIDTH = 32,
    parameter int DIV_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [DIV_W-1:0]       clkdiv,
    input  logic                   start,
    input  logic [NCH*WIDTH-1:0]   data_in,
    spi_multi_master_if.master     spi,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic                   overrun
);

    localparam int EW = $clog2(2*WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2*WIDTH);
    localparam logic [EW-1:0] LAST_FALL_FROM = EW'(2*WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } state_e;

    typedef logic [NCH-1:0][WIDTH-1:0] lanes_t;

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic              sck_q, sck_d;
    logic              ssel_q, ssel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [DIV_W-1:0]  half_q, half_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
    lanes_t            sh_q, sh_d;

    logic start_edge;
    logic half_done;

    assign start_edge = start && !start_q;
    assign half_done  = (div_cnt_q == half_q);

    // NOTE: every variable written here gets its default first, so no path leaves one
    // unassigned and no latch is inferred; this block uses blocking '=' only.
    always_comb begin
        state_d     = state_q;
        start_d     = start;
        sck_d       = sck_q;
        ssel_d      = ssel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;
        half_d      = half_q;
        div_cnt_d   = div_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        sh_d        = sh_q;

        if (start_edge && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        if (state_q != IDLE) begin
            div_cnt_d = half_done ? '0 : div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_edge && en) begin
                    state_d   = LEAD;
                    ssel_d    = 1'b0;
                    busy_d    = 1'b1;
                    half_d    = clkdiv;
                    div_cnt_d = '0;
                    // Lane k already sits at data_in[k*WIDTH +: WIDTH], matching sh_d[k].
                    sh_d      = data_in;
                end
            end
            LEAD: begin
                if (half_done) begin
                    state_d    = SHIFT;
                    sck_d      = 1'b1;
                    edge_cnt_d = EW'(1);
                end
            end
            SHIFT: begin
                if (half_done) begin
                    if (edge_cnt_q == LAST_EDGE) begin
                        state_d = TRAIL;
                    end else begin
                        sck_d      = !sck_q;
                        edge_cnt_d = edge_cnt_q + EW'(1);
                        // Shift on every fall but the last so bit 0 stays up through TRAIL.
                        if (sck_q && edge_cnt_q != LAST_FALL_FROM) begin
                            for (int k = 0; k < NCH; k++) begin
                                sh_d[k] = {sh_q[k][WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
            end
            TRAIL: begin
                if (half_done) begin
                    state_d     = IDLE;
                    ssel_d      = 1'b1;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    sh_d        = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            sck_q       <= 1'b0;
            ssel_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
            half_q      <= '0;
            div_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            // NOTE: the lane shift registers are reset too, because DATA_OUT is taken
            // straight from their MSBs and must read 0 right after reset.
            sh_q        <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            sck_q       <= sck_d;
            ssel_q      <= ssel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
            half_q      <= half_d;
            div_cnt_q   <= div_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            sh_q        <= sh_d;
        end
    end

    always_comb begin
        spi.DATA_OUT = '0;
        for (int k = 0; k < NCH; k++) begin
            spi.DATA_OUT[k] = sh_q[k][WIDTH-1];
        end
    end

    assign spi.SCK   = sck_q;
    assign spi.SSEL  = ssel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/spi_multi_master.md
Name: spi_multi_master

Overview:
- Parametrised successor to the single-lane 32-bit SPI float sender used for inter-board muscle-length and firing-rate links.
- Drives NCH data lanes (biceps, triceps, further muscles) from one shared SCK/SSEL pair, so every lane is framed on the same clock.
- Word width, lane count and divider width are parameters.
- Adds frame counting, overrun detection and a done strobe, which the single-lane sender lacks.
- Sits at board top level; the sim_clk-rate `start` launches one frame per simulation step.

Parameters:
- NCH, 2, number of parallel data lanes sharing SCK/SSEL.
- WIDTH, 32, bits per word per lane.
- DIV_W, 24, width of the clkdiv input.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock (clk1); the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  enables frame launch.
- clkdiv  in  DIV_W  SCK half-period minus one, in clk cycles.
- start  in  1  frame request (sim_clk level); rising edge detected internally.
- data_in  in  NCH*WIDTH  lane k word at [k*WIDTH +: WIDTH].
- SCK  out  1  shared serial clock, idle low (mode 0).
- SSEL  out  1  shared frame select, active low.
- DATA_OUT  out  NCH  per-lane serial data, MSB first.
- busy  out  1  high from frame launch until SSEL returns high.
- done  out  1  one-cycle pulse at frame end.
- frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W.
- overrun  out  1  sticky; set by a start edge while busy.

Behaviour:
- Reset: all outputs are registered. At the first clk edge with reset=1: SCK=0, SSEL=1, DATA_OUT=0, busy=0, done=0, frame_cnt=0, overrun=0, FSM=IDLE, start edge register=0. This applies mid-frame too: the frame is aborted with no done pulse and no frame_cnt change.
- Edge detect: start_q <= start. An edge exists when start && !start_q.
- Half period: H = clkdiv+1 clk cycles.
  - clkdiv is latched at launch; changes mid-frame are ignored.
  - clkdiv=0 gives H=1.
- States:
  - IDLE: SSEL=1, SCK=0. On edge && en: latch all NCH words and clkdiv, go to LEAD. From the next cycle, SSEL=0, busy=1, DATA_OUT[k]=bit WIDTH-1 of lane k.
  - LEAD: hold for H cycles with SCK=0, then go to SHIFT.
  - SHIFT: SCK toggles every H cycles, starting with a rise. Receivers sample on the rise.
    - On each fall except the last, all lanes shift left by one together.
    - After WIDTH rises and WIDTH falls, go to TRAIL.
  - TRAIL: hold for H cycles with SCK=0 and SSEL=0 (last bit held). Then in one cycle: SSEL=1, busy=0, done=1, frame_cnt+1, DATA_OUT=0, go to IDLE.
- Frame length: SSEL is low for exactly (2*WIDTH+2)*H cycles.
- Earliest relaunch is the cycle after done. An edge arriving in the done cycle itself is accepted, because the FSM is in IDLE then.
- Edge while busy: ignored; overrun is set and stays set until reset.
- en low in IDLE: edges are ignored and overrun is not set. en low mid-frame: the frame completes normally.
- data_in changes mid-frame do not affect the frame in flight.
- frame_cnt wraps from all-ones to 0 without any flag.

Test Plan:
- Normal frame:
  - Stimulus: NCH=2, WIDTH=32, clkdiv=13; data_in = {32'hC000_0000, 32'h3F80_0000}; start edge.
  - Required: SSEL low for 924 cycles (66 half periods of 14 cycles).
  - Required: a rising-edge receiver model captures lane0 = 3F800000 and lane1 = C0000000.
  - Required: done pulses once; frame_cnt = 1.
- clkdiv=0:
  - Stimulus: same data, clkdiv=0.
  - Required: SCK period 2 cycles; SSEL low for 66 cycles; captured words correct.
- Overrun:
  - Stimulus: second start edge 100 cycles into a clkdiv=13 frame.
  - Required: overrun=1; the first frame completes correctly; no second frame starts; frame_cnt = 1.
- Reset mid-frame:
  - Stimulus: reset pulsed at the 10th SCK rise.
  - Required: next cycle SSEL=1, SCK=0, DATA_OUT=0, busy=0, frame_cnt=0; no done pulse. A subsequent frame transfers correctly.
- en gating and relaunch:
  - Stimulus: en=0 with a start edge.
  - Required: no SSEL activity and overrun stays 0.
  - Stimulus: start edge coincident with the done cycle.
  - Required: a new frame starts the next cycle.
- Counter wrap:
  - Stimulus: CNT_W=4; 17 frames with data changed between frames.
  - Required: frame_cnt reads 1 after the 17th frame; each frame carries the data present at its launch.
